// File: rtl/lab_pkg.sv
// Shared lab definitions: button-event FSM state encoding and default timing
// constants, specified at the 10 kHz system clock.
package lab_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        HOLD,
        GAP,
        PRESS2
    } btn_state_t;

    localparam int unsigned BTN_LONG_CNT   = 10000;
    localparam int unsigned BTN_DBL_GAP    = 3000;
    localparam int unsigned BTN_REPEAT_CNT = 2000;

endpackage

// File: rtl/button_event.sv
// Classifies a debounced button level into one-cycle event pulses:
// press/release edges, click, double click, long press and hold auto-repeat.
module button_event
    import lab_pkg::*;
#(
    parameter int unsigned CNT_W      = 14,
    parameter int unsigned LONG_CNT   = BTN_LONG_CNT,
    parameter int unsigned DBL_GAP    = BTN_DBL_GAP,
    parameter int unsigned REPEAT_CNT = BTN_REPEAT_CNT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_GAP - 1);
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CNT - 1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_prev_q;
    logic             press_q, release_q, click_q, double_q, long_q, repeat_q, busy_q;
    logic             click_d, double_d, long_d, repeat_d, busy_d;
    logic             rise, fall;

    assign rise = btn_level & ~btn_prev_q;
    assign fall = ~btn_level & btn_prev_q;

    // Edges take priority over a same-cycle terminal count in every state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        click_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                if (fall) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_TC) begin
                    long_d  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_TC) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == DBL_TC) begin
                    click_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == LONG_TC) begin
                    long_d  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            btn_prev_q <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            click_q    <= 1'b0;
            double_q   <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_prev_q <= btn_level;
            press_q    <= rise;
            release_q  <= fall;
            click_q    <= click_d;
            double_q   <= double_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            busy_q     <= busy_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click         = click_q;
    assign double_click  = double_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with short timing parameters; every cycle
// of each scenario is checked against a hand-derived output vector.
module tb_button_event;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_level;
    logic press_pulse, release_pulse, click, double_click, long_press, repeat_pulse, busy;

    int unsigned checks_total  = 0;
    int unsigned checks_passed = 0;

    // Observed vector order: {press, release, click, double, long, repeat, busy}
    localparam logic [6:0] Z   = 7'b0000000;
    localparam logic [6:0] B   = 7'b0000001;
    localparam logic [6:0] PR  = 7'b1000001;
    localparam logic [6:0] RL  = 7'b0100001;
    localparam logic [6:0] RLI = 7'b0100000;
    localparam logic [6:0] CK  = 7'b0010000;
    localparam logic [6:0] DB  = 7'b0101000;
    localparam logic [6:0] LP  = 7'b0000101;
    localparam logic [6:0] RP  = 7'b0000011;

    always #5 clk = ~clk;

    button_event #(
        .CNT_W     (6),
        .LONG_CNT  (20),
        .DBL_GAP   (10),
        .REPEAT_CNT(5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .click        (click),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {press_pulse, release_pulse, click, double_click, long_press, repeat_pulse, busy};
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick_chk(input string tag, input logic [6:0] exp);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    task automatic ticks_chk(input string tag, input int unsigned n, input logic [6:0] exp);
        for (int unsigned i = 0; i < n; i++) tick_chk(tag, exp);
    endtask

    initial begin
        reset_n   = 1'b0;
        btn_level = 1'b0;
        #12;
        check("reset_state", Z);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ticks_chk("idle_after_reset", 2, Z);

        // Short press: high for 4 sampled clocks.
        btn_level = 1'b1;
        tick_chk("short_press_pulse", PR);
        ticks_chk("short_held", 3, B);
        btn_level = 1'b0;
        tick_chk("short_release", RL);
        ticks_chk("short_gap", 9, B);
        tick_chk("short_click", CK);
        ticks_chk("short_idle", 3, Z);

        // Double click: high 3, low 4, high 3.
        btn_level = 1'b1;
        tick_chk("dbl_press1", PR);
        ticks_chk("dbl_held1", 2, B);
        btn_level = 1'b0;
        tick_chk("dbl_release1", RL);
        ticks_chk("dbl_gap", 3, B);
        btn_level = 1'b1;
        tick_chk("dbl_press2", PR);
        ticks_chk("dbl_held2", 2, B);
        btn_level = 1'b0;
        tick_chk("dbl_double_click", DB);
        ticks_chk("dbl_no_click", 12, Z);

        // Long press with repeat: high 37 clocks.
        btn_level = 1'b1;
        tick_chk("long_press_pulse", PR);
        ticks_chk("long_held", 19, B);
        tick_chk("long_press_at_20", LP);
        ticks_chk("hold_a", 4, B);
        tick_chk("repeat_at_25", RP);
        ticks_chk("hold_b", 4, B);
        tick_chk("repeat_at_30", RP);
        ticks_chk("hold_c", 4, B);
        tick_chk("repeat_at_35", RP);
        tick_chk("hold_d", B);
        btn_level = 1'b0;
        tick_chk("hold_release", RLI);
        ticks_chk("hold_no_click", 12, Z);

        // Release exactly when PRESS1 reaches terminal count.
        btn_level = 1'b1;
        tick_chk("race1_press", PR);
        ticks_chk("race1_held", 19, B);
        btn_level = 1'b0;
        tick_chk("race1_release_no_long", RL);
        ticks_chk("race1_gap", 9, B);
        tick_chk("race1_click", CK);
        ticks_chk("race1_idle", 2, Z);

        // Second press exactly when GAP reaches terminal count.
        btn_level = 1'b1;
        tick_chk("race2_press1", PR);
        tick_chk("race2_held1", B);
        btn_level = 1'b0;
        tick_chk("race2_release1", RL);
        ticks_chk("race2_gap", 9, B);
        btn_level = 1'b1;
        tick_chk("race2_press2_no_click", PR);
        btn_level = 1'b0;
        tick_chk("race2_double_click", DB);
        ticks_chk("race2_idle", 12, Z);

        // Reset two clocks into GAP.
        btn_level = 1'b1;
        tick_chk("rst_press", PR);
        tick_chk("rst_held", B);
        btn_level = 1'b0;
        tick_chk("rst_release", RL);
        ticks_chk("rst_gap", 2, B);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_clear", Z);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_held_low", Z);
        reset_n = 1'b1;
        ticks_chk("rst_no_click", 15, Z);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes the debounced, active-high button level from the switch debouncer and classifies it into single-cycle event pulses: raw press/release, single click, double click, long press and hold auto-repeat.
- Sits between the debouncer and the lab's control FSMs, so downstream logic never times button presses itself.
- Runs on the same 10 kHz system clock; default timing parameters are specified at that rate.

Parameters:
- CNT_W, 14: width of the shared interval counter; every *_CNT below must be < 2**CNT_W.
- LONG_CNT, 10000: clocks from press_pulse to long_press (1 s at 10 kHz).
- DBL_GAP, 3000: clocks after a release within which a second press forms a double click (300 ms).
- REPEAT_CNT, 2000: clocks between successive repeat pulses while held after a long press (200 ms).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_level  in  1  debounced button level, 1 = pressed; already synchronous to clk.
- press_pulse  out  1  one-cycle pulse on each 0->1 of btn_level.
- release_pulse  out  1  one-cycle pulse on each 1->0 of btn_level.
- click  out  1  one-cycle pulse: single short press, no second press within DBL_GAP.
- double_click  out  1  one-cycle pulse: second short press released.
- long_press  out  1  one-cycle pulse: held LONG_CNT clocks.
- repeat_pulse  out  1  one-cycle pulse every REPEAT_CNT clocks while held after long_press.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset: all outputs 0; btn_prev = 0; cnt = 0; state = IDLE. Asserting reset mid-sequence aborts it; no pulse is emitted on or after reset release.
- Edge detection: btn_prev registers btn_level; rise = btn_level & ~btn_prev; fall = ~btn_level & btn_prev.
- All outputs are registered. press_pulse / release_pulse are high the cycle after btn_level changes (1-clock latency), in every state.
- Event outputs are mutually exclusive pulses, never high more than 1 cycle.
- FSM states and transitions:
  - IDLE: rise -> PRESS1, cnt = 0.
  - PRESS1: while held, cnt++. If cnt == LONG_CNT-1, pulse long_press, go to HOLD, cnt = 0. On fall, go to GAP, cnt = 0. Fall wins over a same-cycle terminal count.
  - HOLD: while held, cnt++. If cnt == REPEAT_CNT-1, pulse repeat_pulse, cnt = 0. On fall, go to IDLE with no click; fall wins over terminal count.
  - GAP: cnt++. On rise, go to PRESS2, cnt = 0. If cnt == DBL_GAP-1, pulse click and go to IDLE. Rise wins over a same-cycle terminal count: no click.
  - PRESS2: while held, cnt++. On fall, pulse double_click and go to IDLE. If cnt == LONG_CNT-1, pulse long_press, go to HOLD, no double_click.
- Resulting timing:
  - long_press lands exactly LONG_CNT clocks after press_pulse.
  - The first repeat_pulse lands REPEAT_CNT clocks after long_press, then every REPEAT_CNT clocks.
  - click lands DBL_GAP clocks after release_pulse.
- Counter: unsigned CNT_W bits; cleared on every state entry; never wraps, because each terminal count forces a clear or a state change.
- busy = (state != IDLE), registered with state.

Decomposition:
- Shared package lab_pkg holds:
  - typedef enum logic [2:0] btn_state_t {IDLE, PRESS1, HOLD, GAP, PRESS2};
  - default timing constants BTN_LONG_CNT, BTN_DBL_GAP, BTN_REPEAT_CNT.
- Single module, no sub-module. Edge detection is two lines and stays inline.
- A top-level wrapper instances the debouncer, then button_event.

Test Plan:
(bench parameters: LONG_CNT=20, DBL_GAP=10, REPEAT_CNT=5, CNT_W=6)
- Short press: btn_level high 4 clocks, then low.
  - press_pulse 1 clock after the rise; release_pulse 1 clock after the fall.
  - click exactly 10 clocks after release_pulse.
  - No other events; busy drops with click.
- Double click: high 3, low 4, high 3, then low.
  - double_click 1 clock after the second fall.
  - No click; no long_press.
- Long press with repeat: high 37 clocks.
  - long_press 20 clocks after press_pulse.
  - repeat_pulse at +25, +30 and +35.
  - On release: release_pulse only, no click, busy low 1 clock later.
- Boundary races:
  - Release on the clock where PRESS1 cnt = 19 -> no long_press; click follows 10 clocks later.
  - Second press on the clock where GAP cnt = 9 -> no click; PRESS2 entered.
- Reset mid-operation: assert reset_n low 2 clocks into GAP.
  - All outputs 0 immediately (asynchronous); busy = 0.
  - No click after reset release, even with btn_level held low.
